// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester, shared-ALU and response signals of the ALU sharing controller
interface alu_share_ctrl_if #(parameter int CNT_W = 8);
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [3:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0] r0_sel, r1_sel;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic alu_carry;
  logic rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [3:0] rsp_result;
  logic busy;
  logic [CNT_W-1:0] op_count;
  modport slave (
    input r0_valid, r0_a, r0_b, r0_sel, r1_valid, r1_a, r1_b, r1_sel,
    input alu_result, alu_carry, rsp_ready,
    output r0_ready, r1_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, busy, op_count
  );
  modport master (
    output r0_valid, r0_a, r0_b, r0_sel, r1_valid, r1_a, r1_b, r1_sel,
    output alu_result, alu_carry, rsp_ready,
    input r0_ready, r1_ready, alu_a, alu_b, alu_sel,
    input rsp_valid, rsp_id, rsp_result, rsp_carry, busy, op_count
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one 4-bit ALU between two requesters
module alu_share_ctrl #(
  parameter int CNT_W = 8,
  parameter bit FIRST_PRIO = 1'b0
) (
  input logic clk,
  input logic rst_n,
  alu_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic prio, id, g0, g1;
  logic [CNT_W-1:0] cnt;
  assign g0 = state == IDLE && bus.r0_valid && (!bus.r1_valid || !prio);
  assign g1 = state == IDLE && bus.r1_valid && (!bus.r0_valid || prio);
  assign bus.op_count = cnt;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? ((g0 || g1) ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (bus.rsp_ready ? IDLE : RESP);
  always_comb begin
    bus.r0_ready = g0;
    bus.r1_ready = g1;
    bus.busy = state != IDLE;
    bus.rsp_valid = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= FIRST_PRIO;
      id <= 1'b0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_sel <= '0;
      bus.rsp_id <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_carry <= 1'b0;
      cnt <= '0;
    end else if (g0 || g1) begin
      bus.alu_a <= g1 ? bus.r1_a : bus.r0_a;
      bus.alu_b <= g1 ? bus.r1_b : bus.r0_b;
      bus.alu_sel <= g1 ? bus.r1_sel : bus.r0_sel;
      id <= g1;
      prio <= g0;
    end else if (state == EXEC) begin
      bus.rsp_result <= bus.alu_result;
      // carry is only meaningful for add/sub; other ops leave junk in bit 4
      bus.rsp_carry <= bus.alu_carry && bus.alu_sel[2:1] == 2'b00;
      bus.rsp_id <= id;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, carry masking, backpressure, reset and counter wrap
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_share_ctrl_if #(.CNT_W(2)) bus ();
  alu_share_ctrl #(.CNT_W(2), .FIRST_PRIO(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [4:0] alu_r;
  always_comb begin
    alu_r = 5'd0;
    case (bus.alu_sel)
      3'b000: alu_r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: alu_r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'b010: alu_r = {1'b0, bus.alu_a & bus.alu_b};
      3'b011: alu_r = {1'b0, bus.alu_a | bus.alu_b};
      3'b100: alu_r = {1'b0, bus.alu_a ^ bus.alu_b};
      3'b101: alu_r = ~{1'b0, bus.alu_a};
      3'b110: alu_r = {4'd0, bus.alu_a > bus.alu_b};
      default: alu_r = {4'd0, bus.alu_a == bus.alu_b};
    endcase
  end
  assign bus.alu_result = alu_r[3:0];
  assign bus.alu_carry = alu_r[4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input bit r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                    input logic [3:0] er, input bit ec, input logic [1:0] ecnt);
    if (r) begin
      bus.r1_valid = 1'b1; bus.r1_a = a; bus.r1_b = b; bus.r1_sel = sel;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_a = a; bus.r0_b = b; bus.r0_sel = sel;
    end
    #1;
    chk("grant", r ? bus.r1_ready : bus.r0_ready, 1'b1);
    step();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    #1;
    chk("exec_busy", bus.busy, 1'b1);
    chk("exec_no_rsp", bus.rsp_valid, 1'b0);
    chk("exec_alu_a", bus.alu_a, a);
    step();
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_id", bus.rsp_id, r);
    chk("rsp_result", bus.rsp_result, er);
    chk("rsp_carry", bus.rsp_carry, ec);
    chk("op_count", bus.op_count, ecnt);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 1'b0);
    chk("idle", bus.busy, 1'b0);
  endtask
  initial begin
    int ids[$];
    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_sel = '0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_sel = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_count", bus.op_count, 2'd0);
    chk("rst_alu_a", bus.alu_a, 4'd0);
    rst_n = 1'b1;
    step();
    op(1'b0, 4'b1101, 4'b1011, 3'b000, 4'b1000, 1'b1, 2'd1);
    op(1'b1, 4'b1100, 4'b1010, 3'b001, 4'b0010, 1'b0, 2'd2);
    op(1'b1, 4'b1100, 4'b0000, 3'b101, 4'b0011, 1'b0, 2'd3);
    // backpressure: 4th op wraps count to 0, r1 waits with its xor
    bus.r0_valid = 1'b1; bus.r0_a = 4'd1; bus.r0_b = 4'd1; bus.r0_sel = 3'b000;
    bus.r1_valid = 1'b1; bus.r1_a = 4'b0110; bus.r1_b = 4'b0011; bus.r1_sel = 3'b100;
    #1;
    chk("bp_grant0", bus.r0_ready, 1'b1);
    chk("bp_nogrant1", bus.r1_ready, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_result", bus.rsp_result, 4'b0010);
      chk("bp_id", bus.rsp_id, 1'b0);
      chk("bp_ready", {bus.r0_ready, bus.r1_ready}, 2'b00);
      chk("bp_busy", bus.busy, 1'b1);
      chk("bp_count", bus.op_count, 2'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_accept_nogrant", {bus.r0_ready, bus.r1_ready}, 2'b00);
    step();
    bus.rsp_ready = 1'b0;
    bus.r0_valid = 1'b0;
    #1;
    chk("bp_idle", bus.busy, 1'b0);
    op(1'b1, 4'b0110, 4'b0011, 3'b100, 4'b0101, 1'b0, 2'd1);
    // reset during EXEC discards the op
    bus.r1_valid = 1'b1; bus.r1_a = 4'd3; bus.r1_b = 4'd4; bus.r1_sel = 3'b000;
    step();
    bus.r1_valid = 1'b0;
    chk("mid_exec", bus.busy, 1'b1);
    rst_n = 1'b0;
    step();
    chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_count", bus.op_count, 2'd0);
    chk("mid_result", bus.rsp_result, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_rsp", bus.rsp_valid, 1'b0);
    end
    // contention: r0 and, r1 or; prio reset to 0
    bus.r0_valid = 1'b1; bus.r0_a = 4'b0110; bus.r0_b = 4'b0011; bus.r0_sel = 3'b010;
    bus.r1_valid = 1'b1; bus.r1_a = 4'b0110; bus.r1_b = 4'b0011; bus.r1_sel = 3'b011;
    bus.rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 40 && ids.size() < 4; i++) begin
      if (bus.r0_ready && bus.r1_ready) chk("both_ready", 2'b11, 2'b01);
      if ((bus.r0_ready || bus.r1_ready) && bus.busy) chk("ready_busy", bus.busy, 1'b0);
      if (bus.rsp_valid) begin
        ids.push_back(int'(bus.rsp_id));
        chk("ct_result", bus.rsp_result, bus.rsp_id ? 4'b0111 : 4'b0010);
      end
      step();
    end
    chk("ct_count", ids.size(), 4);
    for (int i = 0; i < ids.size(); i++) chk("ct_id", ids[i], i % 2);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares the team's single 4-bit ALU (3-bit op select, 4-bit result plus carry) between two requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand and select lines from registered copies.
- Captures the combinational ALU result one cycle after issue, then returns it tagged with the requester id over a response handshake.
- Sits between the two ALU clients and the shared combinational ALU instance.

Parameters:
- CNT_W, 8: width of the completed-operation counter.
- FIRST_PRIO, 0: requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- r0_valid  input  1  requester 0 has an operation
- r0_ready  output  1  requester 0 operation accepted this cycle
- r0_a  input  4  requester 0 operand A
- r0_b  input  4  requester 0 operand B
- r0_sel  input  3  requester 0 ALU select (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A>B, 111 A==B)
- r1_valid, r1_ready, r1_a, r1_b, r1_sel: same as above, for requester 1
- alu_a  output  4  operand A to the shared ALU
- alu_b  output  4  operand B to the shared ALU
- alu_sel  output  3  select to the shared ALU
- alu_result  input  4  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_carry  input  1  ALU bit 4 (carry/borrow)
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  4  captured result
- rsp_carry  output  1  captured carry
- busy  output  1  high when state is not IDLE
- op_count  output  CNT_W  number of completed responses, wraps modulo 2^CNT_W

Behaviour:
- Clocking and reset:
  - Single clock domain, clk rising edge.
  - Synchronous active-low reset. When rst_n=0 at a clock edge: state=IDLE, prio=FIRST_PRIO, all registered outputs=0 (alu_a, alu_b, alu_sel, rsp_*, op_count).
  - An in-flight operation is discarded on reset; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational:
    - Only one valid: that requester gets ready=1.
    - Both valid: requester prio gets ready=1 and the other gets ready=0.
    - Neither valid: both ready=0.
  - rX_ready is never 1 outside IDLE.
  - Transfer happens when rX_valid and rX_ready are both 1.
  - On transfer: register a, b and sel into alu_a, alu_b and alu_sel; register id; set prio to the other requester; go to EXEC.
  - A requester may drop valid before it is granted; this has no side effects.
- EXEC (exactly 1 cycle):
  - alu_* hold the registered operands.
  - At the end of the cycle, capture rsp_result=alu_result and rsp_id=id.
  - rsp_carry=alu_carry only for sel 000 and 001; otherwise rsp_carry is forced to 0. This masks the ALU's bit-4 artifact on NOT and the logic ops.
  - Increment op_count, wrapping. Go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_result and rsp_carry held stable until rsp_ready=1.
  - On rsp_ready=1: rsp_valid becomes 0 next cycle and the state goes to IDLE.
  - No grant is made in the same cycle as response acceptance.
- Output hold: alu_a, alu_b and alu_sel keep their last values while in IDLE and RESP.
- Timing: latency from accept to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles.
- Fairness: under continuous requests from both requesters, grants strictly alternate 0,1,0,1...

Test Plan:
- Add with carry: r0 sends a=1101, b=1011, sel=000 -> rsp_valid=1 two cycles after accept, rsp_id=0, rsp_result=1000, rsp_carry=1, op_count=1.
- Sub and NOT carry masking: r1 sends 1100-1010, sel=001 -> rsp_result=0010, rsp_carry=0. Then r1 sends a=1100, sel=101 -> rsp_result=0011, rsp_carry=0 even though alu_carry=1.
- Contention: after reset with FIRST_PRIO=0, r0 and r1 hold valid continuously with distinct ops, rsp_ready=1 -> rsp_id sequence 0,1,0,1. r0_ready and r1_ready are never high together, and each is high only in IDLE.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp fields stay stable, both ready signals stay 0 and busy=1. After rsp_ready=1, the state returns to IDLE and the next grant occurs one cycle later.
- Reset mid-operation: assert rst_n=0 in EXEC -> next cycle rsp_valid=0, busy=0, op_count=0, prio=FIRST_PRIO, and no response ever appears for that operation.
- Counter wrap: with CNT_W=2, complete 5 operations -> op_count reads 1,2,3,0,1.
